// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM port arbiter: controller command codes,
// arbiter FSM states and transaction owners.
package sdram_arb_pkg;

  localparam logic [1:0] CMD_IDLE    = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_CPU,
    OWN_VID,
    OWN_REF
  } owner_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval counter with a saturating count of refreshes that are
// due but have not yet been issued to the controller.
module sdram_refresh_timer #(
  parameter int C_refresh_cycles = 780,
  parameter int C_refresh_max    = 8
) (
  input  logic clk_sdram,
  input  logic reset,
  input  logic refresh_issued,
  output logic pending_nz,
  output logic pending_full
);

  localparam int CNT_W  = $clog2(C_refresh_cycles + 1);
  localparam int PEND_W = $clog2(C_refresh_max + 1);
  localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(C_refresh_cycles - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(C_refresh_max);

  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pending;
  logic              tick;

  assign tick         = (cnt == '0);
  assign pending_nz   = (pending != '0);
  assign pending_full = (pending == PEND_MAX);

  // A tick and an issue in the same cycle cancel out.
  always_ff @(posedge clk_sdram) begin
    if (reset) begin
      cnt     <= RELOAD;
      pending <= '0;
    end else begin
      cnt <= tick ? RELOAD : cnt - 1'b1;
      if (tick && !refresh_issued && !pending_full)
        pending <= pending + 1'b1;
      else if (!tick && refresh_issued && pending_nz)
        pending <= pending - 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single SDRAM command engine between CPU accesses, video line
// bursts and auto-refresh, one transaction outstanding at a time.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int C_addr_bits      = 24,
  parameter int C_vid_burst      = 8,
  parameter int C_refresh_cycles = 780,
  parameter int C_refresh_max    = 8
) (
  input  logic                   clk_sdram,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [C_addr_bits-1:0] cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_be,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ack,
  input  logic                   vid_req,
  input  logic [C_addr_bits-1:0] vid_addr,
  output logic [31:0]            vid_rdata,
  output logic                   vid_valid,
  output logic                   vid_done,
  output logic [1:0]             mc_cmd,
  output logic [C_addr_bits-1:0] mc_addr,
  output logic [31:0]            mc_wdata,
  output logic [3:0]             mc_be,
  output logic [3:0]             mc_len,
  input  logic                   mc_busy,
  input  logic                   mc_rvalid,
  input  logic [31:0]            mc_rdata,
  input  logic                   mc_done
);

  localparam logic [3:0] VID_LEN = 4'(C_vid_burst - 1);

  state_t     state;
  owner_t     owner;
  owner_t     grant_own;
  logic       grant_valid;
  logic       owner_we;
  logic       last_vid;
  logic [1:0] issue_cmd;
  logic       issuing;
  logic       pending_nz;
  logic       pending_full;
  logic       cpu_live;
  logic       vid_live;

  // A requester still sees its request high during its own ack/done pulse.
  assign cpu_live = cpu_req & ~cpu_ack;
  assign vid_live = vid_req & ~vid_done;
  assign issuing  = (state == ST_ISSUE) && !mc_busy;
  assign mc_cmd   = issuing ? issue_cmd : CMD_IDLE;

  sdram_refresh_timer #(
    .C_refresh_cycles(C_refresh_cycles),
    .C_refresh_max   (C_refresh_max)
  ) u_timer (
    .clk_sdram     (clk_sdram),
    .reset         (reset),
    .refresh_issued(issuing && owner == OWN_REF),
    .pending_nz    (pending_nz),
    .pending_full  (pending_full)
  );

  always_comb begin
    grant_valid = 1'b1;
    grant_own   = OWN_CPU;
    if (pending_full)                      grant_own = OWN_REF;
    else if (vid_live && !(last_vid && cpu_live)) grant_own = OWN_VID;
    else if (cpu_live)                     grant_own = OWN_CPU;
    else if (pending_nz)                   grant_own = OWN_REF;
    else                                   grant_valid = 1'b0;
  end

  // The grant is deferred while the controller is busy so that refreshes
  // which fall due in the meantime still compete on priority.
  always_ff @(posedge clk_sdram) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_CPU;
      owner_we  <= 1'b0;
      last_vid  <= 1'b0;
      issue_cmd <= CMD_IDLE;
      mc_addr   <= '0;
      mc_wdata  <= '0;
      mc_be     <= '0;
      mc_len    <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      vid_rdata <= '0;
      vid_valid <= 1'b0;
      vid_done  <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      vid_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!mc_busy && grant_valid) begin
            state <= ST_ISSUE;
            owner <= grant_own;
            case (grant_own)
              OWN_CPU: begin
                issue_cmd <= cpu_we ? CMD_WRITE : CMD_READ;
                mc_addr   <= cpu_addr;
                mc_wdata  <= cpu_wdata;
                mc_be     <= cpu_we ? cpu_be : 4'b1111;
                mc_len    <= 4'd0;
                owner_we  <= cpu_we;
                last_vid  <= 1'b0;
              end
              OWN_VID: begin
                issue_cmd <= CMD_READ;
                mc_addr   <= vid_addr;
                mc_wdata  <= '0;
                mc_be     <= 4'b1111;
                mc_len    <= VID_LEN;
                owner_we  <= 1'b0;
                last_vid  <= 1'b1;
              end
              default: begin
                issue_cmd <= CMD_REFRESH;
                mc_addr   <= '0;
                mc_wdata  <= '0;
                mc_be     <= 4'b0000;
                mc_len    <= 4'd0;
                owner_we  <= 1'b0;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (!mc_busy) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mc_rvalid) begin
            if (owner == OWN_CPU && !owner_we) cpu_rdata <= mc_rdata;
            if (owner == OWN_VID) begin
              vid_valid <= 1'b1;
              vid_rdata <= mc_rdata;
            end
          end
          if (mc_done) begin
            state    <= ST_IDLE;
            cpu_ack  <= (owner == OWN_CPU);
            vid_done <= (owner == OWN_VID);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural SDRAM controller, CPU/video
// scoreboards, a table of CPU transactions and multi-cycle corner sequences.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic        clk_sdram = 1'b0;
  logic        reset     = 1'b1;
  logic        cpu_req   = 1'b0;
  logic        cpu_we    = 1'b0;
  logic [23:0] cpu_addr  = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_be    = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        vid_req   = 1'b0;
  logic [23:0] vid_addr  = '0;
  logic [31:0] vid_rdata;
  logic        vid_valid;
  logic        vid_done;
  logic [1:0]  mc_cmd;
  logic [23:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [3:0]  mc_be;
  logic [3:0]  mc_len;
  logic        mc_busy   = 1'b0;
  logic        mc_rvalid = 1'b0;
  logic [31:0] mc_rdata  = '0;
  logic        mc_done   = 1'b0;

  always #5 clk_sdram = ~clk_sdram;

  sdram_port_arbiter dut (
    .clk_sdram(clk_sdram), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .vid_valid(vid_valid), .vid_done(vid_done),
    .mc_cmd(mc_cmd), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_be(mc_be),
    .mc_len(mc_len), .mc_busy(mc_busy), .mc_rvalid(mc_rvalid), .mc_rdata(mc_rdata),
    .mc_done(mc_done)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_for(input logic [23:0] a);
    if (a == 24'h000123) return 32'hDEADBEEF;
    return {8'hC3, a};
  endfunction

  typedef struct {
    logic [1:0]  cmd;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  len;
  } cmd_rec_t;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  exp_cmd;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  cmd_rec_t    cmd_log[$];
  cpu_exp_t    cpu_sb[$];
  logic [31:0] vid_sb[$];
  cmd_rec_t    mdl_rec;
  cpu_exp_t    e_pop;
  int          n_ack     = 0;
  int          n_vdone   = 0;
  int          vid_words = 0;

  // Controller model: one command at a time, read words then a done pulse.
  task automatic run_cmd(input cmd_rec_t r);
    bit abort;
    abort = 0;
    @(negedge clk_sdram);
    if (r.cmd == CMD_READ) begin
      for (int i = 0; i <= int'(r.len) && !abort; i++) begin
        @(negedge clk_sdram);
        if (reset) abort = 1;
        else begin
          mc_rvalid = 1'b1;
          mc_rdata  = data_for(r.addr + 24'(i));
        end
      end
    end else begin
      @(negedge clk_sdram);
    end
    @(negedge clk_sdram);
    mc_rvalid = 1'b0;
    if (!reset && !abort) mc_done = 1'b1;
    @(negedge clk_sdram);
    mc_done = 1'b0;
  endtask

  always begin
    @(posedge clk_sdram);
    if (!reset && mc_cmd != CMD_IDLE && !mc_busy) begin
      mdl_rec.cmd   = mc_cmd;
      mdl_rec.addr  = mc_addr;
      mdl_rec.wdata = mc_wdata;
      mdl_rec.be    = mc_be;
      mdl_rec.len   = mc_len;
      cmd_log.push_back(mdl_rec);
      run_cmd(mdl_rec);
    end
  end

  always @(negedge clk_sdram) begin
    if (!reset && cpu_ack) begin
      n_ack++;
      if (cpu_sb.size() == 0) chk("cpu_ack_unexpected", 32'd1, 32'd0);
      else begin
        e_pop = cpu_sb.pop_front();
        if (e_pop.is_read) chk("cpu_rdata", cpu_rdata, e_pop.rdata);
      end
    end
    if (!reset && vid_valid) begin
      vid_words++;
      if (vid_sb.size() == 0) chk("vid_extra_word", 32'd1, 32'd0);
      else chk("vid_rdata", vid_rdata, vid_sb.pop_front());
    end
    if (!reset && vid_done) begin
      n_vdone++;
      chk("vid_words_before_done", 32'(vid_words), 32'd8);
      vid_words = 0;
    end
  end

  task automatic wait_sig(input int which, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk_sdram); #1;
      case (which)
        0:       ok = cpu_ack;
        1:       ok = vid_done;
        default: ok = vid_valid;
      endcase
    end
  endtask

  task automatic cpu_start(input logic we, input logic [23:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_rd);
    cpu_exp_t e;
    @(negedge clk_sdram);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    e.is_read = !we;
    e.rdata   = exp_rd;
    cpu_sb.push_back(e);
  endtask

  task automatic cpu_finish(input int bound);
    bit ok;
    wait_sig(0, bound, ok);
    chk("cpu_ack_seen", 32'(ok), 32'd1);
    @(negedge clk_sdram);
    cpu_req = 1'b0;
  endtask

  task automatic pop_cmd(output cmd_rec_t r, output bit found);
    found = 0;
    r     = '{default: '0};
    while (cmd_log.size() > 0 && !found) begin
      r = cmd_log.pop_front();
      if (r.cmd != CMD_REFRESH) found = 1;
    end
  endtask

  task automatic count_refresh(input int window, output int first, output int n);
    first = -1;
    n     = 0;
    for (int i = 1; i <= window; i++) begin
      @(posedge clk_sdram); #1;
      if (mc_cmd == CMD_REFRESH) begin
        if (first < 0) first = i;
        n++;
      end
    end
  endtask

  vec_t     tbl[5];
  cmd_rec_t r;
  bit       found;
  bit       ok;
  int       first, nref, a0, viol, vd0;

  initial begin
    tbl[0] = '{1'b0, 24'h000123, 32'h0,        4'b0011, CMD_READ,  4'b1111, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 24'h00ABCD, 32'h12345678, 4'b0101, CMD_WRITE, 4'b0101, 32'h0};
    tbl[2] = '{1'b0, 24'hFFFFFF, 32'h0,        4'b1111, CMD_READ,  4'b1111, 32'hC3FFFFFF};
    tbl[3] = '{1'b1, 24'h000000, 32'hFFFFFFFF, 4'b1000, CMD_WRITE, 4'b1000, 32'h0};
    tbl[4] = '{1'b0, 24'h800000, 32'h0,        4'b0000, CMD_READ,  4'b1111, 32'hC3800000};

    // Reset state, then the first refresh after one full interval.
    repeat (3) @(posedge clk_sdram);
    #1;
    chk("rst_mc_cmd",    32'(mc_cmd),    32'd0);
    chk("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_vid_done",  32'(vid_done),  32'd0);
    chk("rst_mc_addr",   32'(mc_addr),   32'd0);
    chk("rst_cpu_rdata", cpu_rdata,      32'd0);
    @(negedge clk_sdram);
    reset = 1'b0;
    count_refresh(900, first, nref);
    chk("refresh_first_cycle", 32'(first), 32'd781);
    chk("refresh_count",       32'(nref),  32'd1);
    chk("pending_after_ref",   32'(dut.u_timer.pending), 32'd0);
    cmd_log.delete();

    // Table of single CPU transactions.
    for (int v = 0; v < 5; v++) begin
      a0 = n_ack;
      cpu_start(tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].be, tbl[v].exp_rdata);
      cpu_finish(200);
      pop_cmd(r, found);
      chk($sformatf("v%0d_cmd_logged", v), 32'(found), 32'd1);
      chk($sformatf("v%0d_mc_cmd", v),  32'(r.cmd),  32'(tbl[v].exp_cmd));
      chk($sformatf("v%0d_mc_addr", v), 32'(r.addr), 32'(tbl[v].addr));
      chk($sformatf("v%0d_mc_be", v),   32'(r.be),   32'(tbl[v].exp_be));
      chk($sformatf("v%0d_mc_len", v),  32'(r.len),  32'd0);
      if (tbl[v].we) chk($sformatf("v%0d_mc_wdata", v), r.wdata, tbl[v].wdata);
      repeat (4) @(posedge clk_sdram);
      chk($sformatf("v%0d_single_ack", v), 32'(n_ack - a0), 32'd1);
    end

    // Simultaneous video and CPU: video, then CPU, then video again.
    cmd_log.delete();
    cpu_start(1'b0, 24'h000200, 32'h0, 4'b1111, 32'hC3000200);
    vid_addr = 24'h000400;
    vid_req  = 1'b1;
    for (int i = 0; i < 8; i++) vid_sb.push_back({8'hC3, 24'h000400 + 24'(i)});
    wait_sig(1, 300, ok);
    chk("vid1_done_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 8; i++) vid_sb.push_back({8'hC3, 24'h000400 + 24'(i)});
    cpu_finish(300);
    wait_sig(1, 300, ok);
    chk("vid2_done_seen", 32'(ok), 32'd1);
    @(negedge clk_sdram);
    vid_req = 1'b0;
    pop_cmd(r, found);
    chk("arb_1st_len",  32'(r.len),  32'd7);
    chk("arb_1st_addr", 32'(r.addr), 32'h000400);
    pop_cmd(r, found);
    chk("arb_2nd_len",  32'(r.len),  32'd0);
    chk("arb_2nd_addr", 32'(r.addr), 32'h000200);
    pop_cmd(r, found);
    chk("arb_3rd_len",  32'(r.len),  32'd7);

    // Controller busy for a long stretch: refreshes saturate, refresh goes first.
    @(negedge clk_sdram);
    mc_busy = 1'b1;
    a0 = n_ack;
    cpu_start(1'b0, 24'h000321, 32'h0, 4'b1111, 32'hC3000321);
    viol = 0;
    repeat (7100) begin
      @(posedge clk_sdram); #1;
      if (mc_cmd != CMD_IDLE) viol++;
    end
    chk("busy_cmd_idle",     32'(viol), 32'd0);
    chk("busy_pending_sat",  32'(dut.u_timer.pending), 32'd8);
    chk("busy_no_cpu_ack",   32'(n_ack - a0), 32'd0);
    cmd_log.delete();
    @(negedge clk_sdram);
    mc_busy = 1'b0;
    cpu_finish(300);
    chk("busy_first_refresh", 32'(cmd_log.size() > 0 ? cmd_log[0].cmd : CMD_IDLE), 32'(CMD_REFRESH));
    pop_cmd(r, found);
    chk("busy_then_cpu_addr", 32'(r.addr), 32'h000321);
    chk("busy_then_cpu_cmd",  32'(r.cmd),  32'(CMD_READ));

    // Reset during a video burst.
    repeat (100) @(posedge clk_sdram);
    @(negedge clk_sdram);
    vid_addr = 24'h000800;
    vid_req  = 1'b1;
    for (int i = 0; i < 8; i++) vid_sb.push_back({8'hC3, 24'h000800 + 24'(i)});
    wait_sig(2, 300, ok);
    chk("rstmid_valid_seen", 32'(ok), 32'd1);
    @(negedge clk_sdram);
    reset = 1'b1;
    vd0   = n_vdone;
    @(posedge clk_sdram); #1;
    chk("rstmid_vid_valid", 32'(vid_valid), 32'd0);
    chk("rstmid_vid_done",  32'(vid_done),  32'd0);
    chk("rstmid_vid_rdata", vid_rdata,      32'd0);
    chk("rstmid_mc_cmd",    32'(mc_cmd),    32'd0);
    chk("rstmid_mc_len",    32'(mc_len),    32'd0);
    chk("rstmid_mc_addr",   32'(mc_addr),   32'd0);
    @(negedge clk_sdram);
    vid_req = 1'b0;
    @(negedge clk_sdram);
    reset = 1'b0;
    vid_sb.delete();
    vid_words = 0;
    count_refresh(900, first, nref);
    chk("rstmid_refresh_cycle", 32'(first), 32'd781);
    chk("rstmid_no_vid_done",   32'(n_vdone - vd0), 32'd0);
    chk("cpu_sb_drained",       32'(cpu_sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
